// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - sequencer <-> datapath/control-unit signal bundle
interface cpu_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic [15:0]         instr;
  logic                reg_write_req;
  logic                mem_access;
  logic                mem_write;
  logic                will_jump;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         ir;
  logic                rf_we;
  logic                flags_we;
  logic                dm_we;

  modport master (
    input  instr, reg_write_req, mem_access, mem_write, will_jump,
    output pc, ir, rf_we, flags_we, dm_we
  );

  modport slave (
    output instr, reg_write_req, mem_access, mem_write, will_jump,
    input  pc, ir, rf_we, flags_we, dm_we
  );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer
// Optional SEQ_SINGLE_STEP_EN adds a step input and a PAUSE state after WB.
module cpu_sequencer #(
  parameter int         PC_WIDTH    = 8,
  parameter logic [4:0] HALT_OPCODE = 5'b11111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_done,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  cpu_sequencer_if.master bus,
  output logic            halted,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_PAUSE  = 3'd7
  } state_t;

  state_t              st;
  logic [PC_WIDTH-1:0] jump_target;

  assign state       = st;
  assign jump_target = PC_WIDTH'(bus.ir[8:1]);

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;
  logic step_rise;

  assign step_rise = step & ~step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= step;
  end
`endif

  // Strobes are one-cycle pulses: registered on entry to the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= S_LOAD;
      bus.pc       <= '0;
      bus.ir       <= 16'h0000;
      bus.rf_we    <= 1'b0;
      bus.flags_we <= 1'b0;
      bus.dm_we    <= 1'b0;
      halted       <= 1'b0;
    end else begin
      bus.rf_we    <= 1'b0;
      bus.flags_we <= 1'b0;
      bus.dm_we    <= 1'b0;
      case (st)
        S_LOAD: begin
          bus.pc <= '0;
          if (load_done) st <= S_FETCH;
        end
        S_FETCH: begin
          bus.ir <= bus.instr;
          st     <= S_DECODE;
        end
        S_DECODE: begin
          if (bus.ir[15:11] == HALT_OPCODE) begin
            st     <= S_HALT;
            halted <= 1'b1;
          end else begin
            st           <= S_EXEC;
            bus.flags_we <= 1'b1;
          end
        end
        S_EXEC: begin
          if (bus.mem_access) begin
            st        <= S_MEM;
            bus.dm_we <= bus.mem_write;
          end else begin
            st        <= S_WB;
            bus.rf_we <= bus.reg_write_req;
          end
        end
        S_MEM: begin
          st        <= S_WB;
          bus.rf_we <= bus.reg_write_req;
        end
        S_WB: begin
          bus.pc <= bus.will_jump ? jump_target : bus.pc + PC_WIDTH'(1);
`ifdef SEQ_SINGLE_STEP_EN
          st     <= S_PAUSE;
`else
          st     <= S_FETCH;
`endif
        end
        S_HALT: begin
          st <= S_HALT;
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE: begin
          if (step_rise) st <= S_FETCH;
        end
`endif
        default: begin
          st <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

  typedef struct {
    logic [15:0] instr;
    logic        rw;
    logic        ma;
    logic        mw;
    logic        wj;
    int          cycles;
    int          rf;
    int          fl;
    int          dm;
    logic [7:0]  pc_next;
    logic [2:0]  st_end;
  } vec_t;

`ifdef SEQ_SINGLE_STEP_EN
  localparam logic [2:0] ST_AFTER = 3'd7;
`else
  localparam logic [2:0] ST_AFTER = 3'd1;
`endif

  logic       clk;
  logic       rst;
  logic       load_done;
  logic       step;
  logic       halted;
  logic [2:0] state;
  int         n_cmp;
  int         n_fail;
  vec_t       sb[$];
  vec_t       vecs[9];

  cpu_sequencer_if #(.PC_WIDTH(8)) bus();

  cpu_sequencer #(.PC_WIDTH(8), .HALT_OPCODE(5'b11111)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_done (load_done),
`ifdef SEQ_SINGLE_STEP_EN
    .step      (step),
`endif
    .bus       (bus.master),
    .halted    (halted),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_and_load();
    rst = 1'b1;
    load_done = 1'b0;
    step = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_pc", 32'(bus.pc), 32'd0);
    check("reset_ir", 32'(bus.ir), 32'd0);
    check("reset_strobes", {29'd0, bus.rf_we, bus.flags_we, bus.dm_we}, 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    load_done = 1'b1;
    @(negedge clk);
    check("load_to_fetch", 32'(state), 32'd1);
    check("first_fetch_pc", 32'(bus.pc), 32'd0);
    load_done = 1'b0;
  endtask

  // In single-step builds: confirm the pause holds with step high, then pulse a new edge.
  task automatic advance();
`ifdef SEQ_SINGLE_STEP_EN
    if (state == 3'd7) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("pause_hold", 32'(state), 32'd7);
        check("pause_strobes", {29'd0, bus.rf_we, bus.flags_we, bus.dm_we}, 32'd0);
      end
      step = 1'b0;
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      check("step_to_fetch", 32'(state), 32'd1);
    end
`endif
  endtask

  task automatic run_instr(input vec_t v);
    vec_t e;
    int   cyc, rf, fl, dm, bad;
    logic done;
    bus.instr         = v.instr;
    bus.reg_write_req = v.rw;
    bus.mem_access    = v.ma;
    bus.mem_write     = v.mw;
    bus.will_jump     = v.wj;
    sb.push_back(v);
    cyc = 0; rf = 0; fl = 0; dm = 0; bad = 0; done = 1'b0;
    check("instr_start_fetch", 32'(state), 32'd1);
    while (!done && cyc < 20) begin
      cyc++;
      rf += int'(bus.rf_we);
      fl += int'(bus.flags_we);
      dm += int'(bus.dm_we);
      if ((bus.rf_we && state != 3'd5) || (bus.flags_we && state != 3'd3) ||
          (bus.dm_we && state != 3'd4)) bad++;
      @(negedge clk);
      if (state == 3'd1 || state == 3'd6 || state == 3'd7) done = 1'b1;
    end
    e = sb.pop_front();
    check("instr_timeout", 32'(done), 32'd1);
    check("cycles", 32'(cyc), 32'(e.cycles));
    check("rf_we_count", 32'(rf), 32'(e.rf));
    check("flags_we_count", 32'(fl), 32'(e.fl));
    check("dm_we_count", 32'(dm), 32'(e.dm));
    check("strobe_wrong_state", 32'(bad), 32'd0);
    check("pc_next", 32'(bus.pc), 32'(e.pc_next));
    check("ir_latched", 32'(bus.ir), 32'(e.instr));
    check("end_state", 32'(state), 32'(e.st_end));
    check("halted", 32'(halted), 32'(e.st_end == 3'd6));
  endtask

  initial begin
    int   cnt;
    logic seen;
    n_cmp = 0;
    n_fail = 0;
    bus.instr = 16'h0000;
    bus.reg_write_req = 1'b0;
    bus.mem_access = 1'b0;
    bus.mem_write = 1'b0;
    bus.will_jump = 1'b0;

    //          instr     rw    ma    mw    wj   cyc rf fl dm  pc_next st_end
    vecs[0] = '{16'h0843, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1, 1, 0, 8'h01, ST_AFTER};
    vecs[1] = '{16'h0A45, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1, 1, 0, 8'h02, ST_AFTER};
    vecs[2] = '{16'h7123, 1'b0, 1'b1, 1'b1, 1'b0, 5, 0, 1, 1, 8'h03, ST_AFTER};
    vecs[3] = '{16'h6123, 1'b1, 1'b1, 1'b0, 1'b0, 5, 1, 1, 0, 8'h04, ST_AFTER};
    vecs[4] = '{16'h8080, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0, 1, 0, 8'h40, ST_AFTER};
    vecs[5] = '{16'h8080, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0, 1, 0, 8'h41, ST_AFTER};
    vecs[6] = '{16'h81FE, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0, 1, 0, 8'hFF, ST_AFTER};
    vecs[7] = '{16'h0843, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1, 1, 0, 8'h00, ST_AFTER};
    vecs[8] = '{16'hF800, 1'b1, 1'b1, 1'b1, 1'b1, 2, 0, 0, 0, 8'h00, 3'd6};

    reset_and_load();
    for (int i = 0; i < 9; i++) begin
      if (i == 8) vecs[8].pc_next = bus.pc;
      advance();
      run_instr(vecs[i]);
    end

    for (int i = 0; i < 5; i++) begin
      load_done = i[0];
      bus.will_jump = ~i[0];
      bus.instr = 16'h1234;
      @(negedge clk);
      check("halt_state_hold", 32'(state), 32'd6);
      check("halt_pc_hold", 32'(bus.pc), 32'd0);
      check("halt_ir_hold", 32'(bus.ir), 32'hF800);
      check("halt_strobes", {29'd0, bus.rf_we, bus.flags_we, bus.dm_we}, 32'd0);
    end

    reset_and_load();
    vecs[8].pc_next = 8'h02;
    run_instr(vecs[0]);
    advance();
    run_instr(vecs[1]);
    advance();
    run_instr(vecs[8]);

    reset_and_load();
    bus.instr = vecs[2].instr;
    bus.reg_write_req = 1'b0;
    bus.mem_access = 1'b1;
    bus.mem_write = 1'b1;
    bus.will_jump = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (state == 3'd4) seen = 1'b1;
    end
    check("reach_mem", 32'(seen), 32'd1);
    check("mem_dm_we", 32'(bus.dm_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dm_we", 32'(bus.dm_we), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_pc", 32'(bus.pc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cnt += int'(bus.rf_we) + int'(bus.flags_we) + int'(bus.dm_we);
      if (state != 3'd0) cnt += 100;
    end
    check("post_rst_idle", 32'(cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 16-bit MIPS-style processor. It holds the processor idle while the host loads instruction memory. It then steps each instruction through fetch, decode, execute, optional memory access and write-back, and owns the program counter and instruction register. It turns the control unit's decoded levels into one-cycle write strobes for the register file, flag register and data RAM. It stops at a halt opcode.

## Interface
Parameters:
- PC_WIDTH, 8, width of program counter / instruction-memory address
- HALT_OPCODE, 5'b11111, opcode (ir[15:11]) that stops execution

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load_done  in  1  host level: instruction memory loaded, start execution
- instr  in  16  instruction-memory read data at address pc
- reg_write_req  in  1  control-unit decode: instruction writes a register
- mem_access  in  1  control-unit decode: instruction touches data RAM
- mem_write  in  1  control-unit decode: data-RAM access is a store
- will_jump  in  1  jump-resolution output, valid once flags are updated
- pc  out  PC_WIDTH  program counter / instruction-memory address
- ir  out  16  latched instruction, feeds control unit and register addresses
- rf_we  out  1  register-file write strobe
- flags_we  out  1  zero/sign/overflow flag capture strobe
- dm_we  out  1  data-RAM write strobe
- halted  out  1  high while in HALT
- state  out  3  current state, for debug LEDs

## Operation
- States and encoding: LOAD=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, PAUSE=7.
- Reset (asynchronous, any state) forces:
  - state=LOAD, pc=0, ir=16'h0000
  - rf_we=flags_we=dm_we=0, halted=0
  - an in-flight instruction is abandoned with no strobe.
- LOAD:
  - pc held at 0.
  - load_done=1 → FETCH; otherwise stay.
  - Host memory writes proceed externally. A write in the same cycle as load_done completes normally.
- FETCH: ir ← instr at the clock edge ending the state. → DECODE.
- DECODE:
  - ir[15:11]==HALT_OPCODE → HALT.
  - Otherwise → EXEC.
- EXEC:
  - flags_we=1 for this cycle.
  - mem_access=1 → MEM; otherwise → WB.
- MEM:
  - dm_we=mem_write for this cycle.
  - → WB.
- WB:
  - rf_we=reg_write_req for this cycle.
  - pc ← will_jump ? ir[8:1] (zero-extended/truncated to PC_WIDTH) : pc+1. Increment wraps modulo 2^PC_WIDTH (0xFF→0x00 at default).
  - → FETCH, or → PAUSE when SEQ_SINGLE_STEP_EN is defined.
- HALT:
  - halted=1, pc and ir frozen.
  - All inputs are ignored, load_done included. Only rst leaves HALT.
- Strobes are registered, decoded from the current state, and never high in LOAD, FETCH, DECODE, HALT or PAUSE.
- Decode inputs are sampled only in the state that uses them. Changes in other states have no effect.

## Timing
- All transitions occur on the rising clk edge. Exactly one state per cycle, with no wait states other than LOAD, PAUSE and HALT.
- Cycle counts:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Memory instruction: 5 cycles.
  - Halt: 2 cycles to HALT.
- instr must be valid combinationally within the FETCH cycle for the current pc. ir is valid from the first DECODE cycle.
- will_jump is sampled in WB, after flags_we in EXEC has updated the flags. A jump uses the flags of the immediately preceding instruction's EXEC only if that instruction is the jump itself; otherwise the flags come from the last flag-writing EXEC.
- The new pc is visible in the FETCH cycle following WB.
- The first FETCH after reset is at pc=0, one cycle after load_done is sampled high.

## Configuration
- SEQ_SINGLE_STEP_EN defined:
  - Adds input `step` (1 bit).
  - WB → PAUSE. PAUSE holds all state and outputs, with strobes 0.
  - A rising edge of step (registered edge detect) → FETCH.
  - step held high advances exactly one instruction per rising edge.
- SEQ_SINGLE_STEP_EN undefined: no step port, WB → FETCH directly, and state 7 is unreachable.

## Test plan
- Reset with load_done=0 for 10 cycles → state=0, pc=0, all strobes 0. Raise load_done → state=1 on the next edge.
- Program "ADD; ADD; HALT" at 0x00–0x02 → one flags_we and one rf_we per ADD, 4 cycles each. HALT reached with pc=0x02, halted=1, state=6.
- Store instruction (mem_access=1, mem_write=1, reg_write_req=0) → EXEC, MEM, WB sequence. dm_we=1 only in MEM, rf_we=0, 5 cycles total.
- Jump with will_jump=1, ir[8:1]=8'h40 → pc=0x40 in the next FETCH. Same jump with will_jump=0 → pc=pc+1. Non-jump at pc=0xFF → pc wraps to 0x00.
- Assert rst during MEM with mem_write=1 → dm_we falls immediately (asynchronous reset), state=LOAD, pc=0. No strobe fires after reset release until load_done.
- SEQ_SINGLE_STEP_EN defined → the sequencer stops in state 7 after each WB. Each step rising edge executes exactly one instruction; step held high runs no further.
